// File: rtl/div_seq_32.sv
// div_seq_32: RV32M DIV/DIVU/REM/REMU sequencer sharing one 32-bit ripple subtractor
module div_sub_32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] diff,
   output logic        cout
);
   assign {cout, diff} = {1'b0, a} + {1'b0, ~b} + 33'd1;
endmodule

module div_seq_32 (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);
   typedef enum logic [2:0] {IDLE, ABS_A, ABS_B, CALC, FIX, DONE} state_t;
   state_t      state_q, state_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d;
   logic [31:0] dividend_q, dividend_d, divisor_q, divisor_d, result_q, result_d;
   logic [4:0]  cnt_q, cnt_d;
   logic        neg_res_q, neg_res_d;
   logic [1:0]  op_q, op_d;
   logic [31:0] sub_a, sub_b, diff, sh, v;
   logic        cout, sgn;
   div_sub_32 u_sub (.a(sub_a), .b(sub_b), .diff(diff), .cout(cout));
   assign sgn    = ~op_q[0];
   assign sh     = {rem_q[30:0], quo_q[31]};
   assign v      = op_q[1] ? rem_q : quo_q;
   assign busy   = state_q != IDLE;
   assign done   = state_q == DONE;
   assign result = result_q;
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
      quo_d      = quo_q;
      dmag_d     = dmag_q;
      cnt_d      = cnt_q;
      neg_res_d  = neg_res_q;
      op_d       = op_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      result_d   = result_q;
      sub_a      = 32'd0;
      sub_b      = 32'd0;
      case (state_q)
         IDLE: if (start) begin
            op_d       = op;
            dividend_d = dividend;
            divisor_d  = divisor;
            neg_res_d  = ~op[0] & (op[1] ? dividend[31] : dividend[31] ^ divisor[31]);
            if (divisor == 32'd0) begin
               result_d = op[1] ? dividend : 32'hFFFF_FFFF;
               state_d  = DONE;
            end else if (~op[0] && dividend == 32'h8000_0000 && divisor == 32'hFFFF_FFFF) begin
               result_d = op[1] ? 32'd0 : 32'h8000_0000;
               state_d  = DONE;
            end else begin
               state_d = ABS_A;
            end
         end
         ABS_A: begin
            sub_b   = dividend_q;
            quo_d   = (sgn & dividend_q[31]) ? diff : dividend_q;
            rem_d   = 32'd0;
            state_d = ABS_B;
         end
         ABS_B: begin
            sub_b   = divisor_q;
            dmag_d  = (sgn & divisor_q[31]) ? diff : divisor_q;
            cnt_d   = 5'd31;
            state_d = CALC;
         end
         CALC: begin
            sub_a   = sh;
            sub_b   = dmag_q;
            rem_d   = cout ? diff : sh;
            quo_d   = {quo_q[30:0], cout};
            cnt_d   = cnt_q - 5'd1;
            state_d = (cnt_q == 5'd0) ? FIX : CALC;
         end
         FIX: begin
            sub_b    = v;
            result_d = neg_res_q ? diff : v;
            state_d  = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         rem_q      <= 32'd0;
         quo_q      <= 32'd0;
         dmag_q     <= 32'd0;
         cnt_q      <= 5'd0;
         neg_res_q  <= 1'b0;
         op_q       <= 2'd0;
         dividend_q <= 32'd0;
         divisor_q  <= 32'd0;
         result_q   <= 32'd0;
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
         quo_q      <= quo_d;
         dmag_q     <= dmag_d;
         cnt_q      <= cnt_d;
         neg_res_q  <= neg_res_d;
         op_q       <= op_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         result_q   <= result_d;
      end
   end
endmodule

// File: tb/tb_div_seq_32.sv
// tb_div_seq_32: directed vectors checked against a cycle-level arithmetic reference model
module tb_div_seq_32;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [1:0]  op = 2'd0;
   logic [31:0] dividend = 32'd0, divisor = 32'd0;
   logic        busy, done;
   logic [31:0] result;
   int total = 0, bad = 0;
   int m_left = 0;
   logic [31:0] m_result = 32'd0, m_pending = 32'd0;

   div_seq_32 dut (.clk(clk), .rst(rst), .start(start), .op(op), .dividend(dividend),
      .divisor(divisor), .busy(busy), .done(done), .result(result));

   always #5 clk = ~clk;

   function automatic logic is_special(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   endfunction

   function automatic logic [31:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
      if (!o[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
         return o[1] ? 32'(sa % sb) : 32'(sa / sb);
      end
      return o[1] ? a % b : a / b;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_left   = 0;
         m_result = 32'd0;
      end else if (m_left == 0) begin
         if (start) begin
            if (is_special(op, dividend, divisor)) begin
               m_result = ref_div(op, dividend, divisor);
               m_left   = 1;
            end else begin
               m_pending = ref_div(op, dividend, divisor);
               m_left    = 36;
            end
         end
      end else begin
         m_left = m_left - 1;
         if (m_left == 1) m_result = m_pending;
      end
   end

   always @(negedge clk) begin
      total += 3;
      if (busy !== (m_left != 0)) begin bad++; $display("FAIL busy: got %b want %b", busy, m_left != 0); end
      if (done !== (m_left == 1)) begin bad++; $display("FAIL done: got %b want %b", done, m_left == 1); end
      if (result !== m_result) begin bad++; $display("FAIL result: got %h want %h", result, m_result); end
      if (m_left >= 3 && m_left <= 34) begin
         total++;
         assert (dut.rem_q[31] == 1'b0) else begin bad++; $display("FAIL rem31_invariant: got 1 want 0"); end
      end
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin bad++; $display("FAIL %s: got %h want %h", name, got, want); end
   endtask

   task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
      int n, dn;
      logic [31:0] r;
      logic sp;
      sp = is_special(o, a, b);
      check({name, "_model"}, ref_div(o, a, b), exp);
      @(negedge clk);
      start = 1'b1; op = o; dividend = a; divisor = b;
      @(negedge clk);
      start = 1'b0; dividend = $urandom; divisor = $urandom; op = 2'($urandom);
      n = 0; dn = -1; r = 32'hDEAD_BEEF;
      while (busy && n < 60) begin
         if (done) begin dn = n; r = result; end
         @(negedge clk);
         n++;
      end
      check({name, "_result"}, r, exp);
      check({name, "_done_lat"}, 32'(dn), sp ? 32'd0 : 32'd35);
      check({name, "_busy_len"}, 32'(n), sp ? 32'd1 : 32'd36);
      check({name, "_hold"}, result, exp);
   endtask

   initial begin
      int dcnt, d1, d2;
      logic [31:0] r;
      @(negedge clk);
      @(negedge clk);
      check("reset_result", result, 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      rst = 1'b0;
      run_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14);
      run_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2);
      run_op("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
      run_op("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
      run_op("div_7_m2", 2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD);
      run_op("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1);
      run_op("divu_big", 2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1);
      run_op("remu_big", 2'b11, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE);
      run_op("divu_max_1", 2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF);
      run_op("div_min_2", 2'b00, 32'h8000_0000, 32'd2, 32'hC000_0000);
      run_op("div_5_0", 2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF);
      run_op("remu_5_0", 2'b11, 32'd5, 32'd0, 32'd5);
      run_op("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
      run_op("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
      run_op("rem_m100_7", 2'b10, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE);
      // start pulsed mid-CALC must not disturb the running division
      @(negedge clk);
      start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (10) @(negedge clk);
      start = 1'b1; op = 2'b00; dividend = 32'd5; divisor = 32'd0;
      @(negedge clk);
      start = 1'b0;
      d1 = 0; r = 32'd0;
      while (!done && d1 < 60) begin @(negedge clk); d1++; end
      r = result;
      check("ignored_start_result", r, 32'd14);
      check("ignored_start_done", 32'(done), 32'd1);
      repeat (2) @(negedge clk);
      check("ignored_start_idle", 32'(busy), 32'd0);
      // reset on the 10th CALC edge (E12)
      start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_result", result, 32'd0);
      run_op("after_rst", 2'b01, 32'd1000, 32'd9, 32'd111);
      // start held high: accepts at E0 and E37
      @(negedge clk);
      start = 1'b1; op = 2'b01; dividend = 32'd100; divisor = 32'd7;
      dcnt = 0; d1 = -1; d2 = -1;
      for (int i = 0; i < 74; i++) begin
         @(negedge clk);
         if (done) begin
            if (dcnt == 0) d1 = i; else d2 = i;
            dcnt++;
         end
      end
      start = 1'b0;
      check("held_done_count", 32'(dcnt), 32'd2);
      check("held_first_done", 32'(d1), 32'd35);
      check("held_period", 32'(d2 - d1), 32'd37);
      check("held_result", result, 32'd14);
      repeat (3) @(negedge clk);
      check("held_idle", 32'(busy), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
